// File: rtl/fadd_sched_if.sv
// Purpose : requester-side bundle for fadd_sched (requests in, one-hot responses out).
// Latency : n/a (wires only).
// Backpressure: req_ready is the per-requester grant; responses cannot be stalled.
// Ports   : req_valid/req_ready/req_a/req_b (+req_sub when FADD_SCHED_SUB_EN), rsp_valid/rsp_data.
//           master = client side, slave = scheduler side.
interface fadd_sched_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
`ifdef FADD_SCHED_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;

`ifdef FADD_SCHED_SUB_EN
  modport master (output req_valid, req_a, req_b, req_sub, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_a, req_b, req_sub, output req_ready, rsp_valid, rsp_data);
`else
  modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/fadd_sched.sv
// Purpose : round-robin share of one floating-point adder among NREQ requesters, results routed
//           back by a tag pipeline. Optional FADD_SCHED_SUB_EN adds req_sub (flip B sign -> A-B).
// Latency : handshake to rsp_valid = LAT+1 edges; 1 op/cycle throughput, responses in issue order.
// Backpressure: one-hot grant on req_ready (none while hold/rst); no response backpressure.
// Ports   : clk, rst (sync, active-high), hold, cl (fadd_sched_if.slave), fa_a/fa_b (registered
//           operands to adder), fa_out (adder result, LAT cycles after issue), inflight.
module fadd_sched #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  fadd_sched_if.slave              cl,
  output logic [N-1:0]             fa_a,
  output logic [N-1:0]             fa_b,
  input  logic [N-1:0]             fa_out,
  output logic [$clog2(LAT+2)-1:0] inflight
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LAT+2);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [N-1:0]    b_raw;
  logic [N-1:0]    b_sel;
  int              idx;

  // Tag pipeline: one valid bit and requester id per adder stage.
  logic [LAT-1:0]  tag_vld;
  logic [IDW-1:0]  tag_id [LAT];
  logic            rsp_fire;

  // Search from ptr upward, wrapping; first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!hold && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!gnt_any && cl.req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign cl.req_ready = gnt;

  always_comb begin
    b_raw = cl.req_b[gnt_id*N +: N];
`ifdef FADD_SCHED_SUB_EN
    b_sel = {b_raw[N-1] ^ cl.req_sub[gnt_id], b_raw[N-2:0]};
`else
    b_sel = b_raw;
`endif
  end

  assign rsp_fire = tag_vld[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      fa_a         <= '0;
      fa_b         <= '0;
      ptr          <= '0;
      tag_vld      <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
      cl.rsp_valid <= '0;
      cl.rsp_data  <= '0;
      inflight     <= '0;
    end else begin
      if (gnt_any) begin
        fa_a <= cl.req_a[gnt_id*N +: N];
        fa_b <= b_sel;
        ptr  <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      end
      tag_vld[0] <= gnt_any;
      tag_id[0]  <= gnt_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      // Result leaves the adder as its tag leaves the last stage.
      cl.rsp_valid <= '0;
      if (rsp_fire) begin
        cl.rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << tag_id[LAT-1];
        cl.rsp_data  <= fa_out;
      end
      // Issue and retire in the same cycle cancel out.
      case ({gnt_any, rsp_fire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule
